// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet MAC transmit framer driving an RMII (2-bit) or MII (4-bit) PHY.
// Emits preamble/SFD, header, payload with zero padding and CRC-32 FCS; aborts on underrun or oversize.
module eth_tx_framer #(
   parameter int pMII_WIDTH   = 2,
   parameter int pMIN_PAYLOAD = 46,
   parameter int pMAX_PAYLOAD = 1500,
   parameter int pIFG_BYTES   = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [47:0]           i_dest_addr,
   input  logic [47:0]           i_src_addr,
   input  logic [15:0]           i_len_type,
   input  logic [7:0]            i_s_data,
   input  logic                  i_s_valid,
   input  logic                  i_s_last,
   output logic                  o_s_ready,
   output logic [pMII_WIDTH-1:0] o_txd,
   output logic                  o_tx_en,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_underrun,
   output logic [3:0]            o_state
);
   localparam int B  = 8 / pMII_WIDTH;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam int PW = $clog2(pMAX_PAYLOAD + 2);

   typedef enum logic [3:0] {
      IDLE, PREAMBLE, SFD, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, PAD, FCS, DRAIN, IFG
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [BW-1:0]   r_beat, w_beat_nxt;
   logic [7:0]      r_byte, w_byte_nxt;
   logic [PW-1:0]   r_pay, w_pay_nxt;
   logic            r_last_seen, w_last_nxt;
   logic [7:0]      r_shift;
   logic            r_tx_en, w_tx_en_nxt;
   logic [31:0]     r_crc;
   logic [111:0]    r_hdr;
   logic            r_frame_done, r_underrun;
   logic            w_last_beat, w_load, w_crc_en, w_hdr_shift, w_start;
   logic            w_s_ready, w_abort, w_done;
   logic [7:0]      w_load_byte, w_fcs_byte;
   logic [31:0]     w_fcs;
   logic [1:0]      w_fcs_sel;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign w_last_beat = (r_beat == BW'(B - 1));
   assign w_fcs       = ~r_crc;
   assign w_fcs_sel   = r_byte[1:0] + 2'd1;
   assign w_fcs_byte  = w_fcs[{w_fcs_sel, 3'b000} +: 8];

   // Stream handshake: a byte transfers on a cycle with i_s_valid & o_s_ready;
   // o_s_ready is a function of registered state only and never waits on i_s_valid.
   assign o_s_ready    = w_s_ready;
   assign o_txd        = r_shift[pMII_WIDTH-1:0];
   assign o_tx_en      = r_tx_en;
   assign o_busy       = (r_state != IDLE);
   assign o_frame_done = r_frame_done;
   assign o_underrun   = r_underrun;
   assign o_state      = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = w_last_beat ? '0 : r_beat + BW'(1);
      w_byte_nxt  = w_last_beat ? r_byte + 8'd1 : r_byte;
      w_load      = w_last_beat;
      w_load_byte = 8'h00;
      w_crc_en    = 1'b0;
      w_hdr_shift = 1'b0;
      w_start     = 1'b0;
      w_s_ready   = 1'b0;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      w_tx_en_nxt = r_tx_en;
      w_pay_nxt   = r_pay;
      w_last_nxt  = r_last_seen;
      case (r_state)
         IDLE: begin
            w_beat_nxt = '0;
            w_byte_nxt = '0;
            w_load     = 1'b0;
            if (i_s_valid) begin
               w_state_nxt = PREAMBLE;
               w_start     = 1'b1;
               w_load      = 1'b1;
               w_load_byte = 8'h55;
               w_tx_en_nxt = 1'b1;
               w_pay_nxt   = '0;
               w_last_nxt  = 1'b0;
            end
         end
         PREAMBLE: begin
            w_load_byte = 8'h55;
            if (w_last_beat && r_byte == 8'd6) begin
               w_state_nxt = SFD;
               w_byte_nxt  = '0;
               w_load_byte = 8'hD5;
            end
         end
         SFD, DEST_ADDR, SRC_ADDR: begin
            // Header bytes come from the latched shift register, MSB byte first.
            w_load_byte = r_hdr[111:104];
            w_hdr_shift = w_last_beat;
            w_crc_en    = w_last_beat;
            if (w_last_beat && (r_state == SFD || r_byte == 8'd5)) begin
               w_state_nxt = (r_state == SFD) ? DEST_ADDR : (r_state == DEST_ADDR) ? SRC_ADDR : LEN_TYPE;
               w_byte_nxt  = '0;
            end
         end
         LEN_TYPE: begin
            if (w_last_beat && r_byte == 8'd0) begin
               w_load_byte = r_hdr[111:104];
               w_hdr_shift = 1'b1;
               w_crc_en    = 1'b1;
            end else if (w_last_beat) begin
               w_s_ready = 1'b1;
               if (i_s_valid) begin
                  w_state_nxt = DATA;
                  w_byte_nxt  = '0;
                  w_load_byte = i_s_data;
                  w_crc_en    = 1'b1;
                  w_pay_nxt   = PW'(1);
                  w_last_nxt  = i_s_last;
               end else begin
                  w_abort = 1'b1;
               end
            end
         end
         DATA: begin
            w_byte_nxt = '0;
            if (w_last_beat) begin
               if (r_last_seen) begin
                  if (r_pay < PW'(pMIN_PAYLOAD)) begin
                     w_state_nxt = PAD;
                     w_crc_en    = 1'b1;
                     w_pay_nxt   = r_pay + PW'(1);
                  end else begin
                     w_state_nxt = FCS;
                     w_load_byte = w_fcs[7:0];
                  end
               end else if (r_pay == PW'(pMAX_PAYLOAD)) begin
                  w_abort = 1'b1;
               end else begin
                  w_s_ready = 1'b1;
                  if (i_s_valid) begin
                     w_load_byte = i_s_data;
                     w_crc_en    = 1'b1;
                     w_pay_nxt   = r_pay + PW'(1);
                     w_last_nxt  = i_s_last;
                  end else begin
                     w_abort = 1'b1;
                  end
               end
            end
         end
         PAD: begin
            w_byte_nxt = '0;
            if (w_last_beat) begin
               if (r_pay >= PW'(pMIN_PAYLOAD)) begin
                  w_state_nxt = FCS;
                  w_load_byte = w_fcs[7:0];
               end else begin
                  w_crc_en  = 1'b1;
                  w_pay_nxt = r_pay + PW'(1);
               end
            end
         end
         FCS: begin
            w_load_byte = w_fcs_byte;
            if (w_last_beat && r_byte == 8'd3) begin
               w_state_nxt = IFG;
               w_byte_nxt  = '0;
               w_load_byte = 8'h00;
               w_tx_en_nxt = 1'b0;
               w_done      = 1'b1;
            end
         end
         DRAIN: begin
            w_beat_nxt = '0;
            w_byte_nxt = '0;
            w_load     = 1'b0;
            w_s_ready  = 1'b1;
            if (i_s_valid && i_s_last) w_state_nxt = IFG;
         end
         IFG: begin
            if (w_last_beat && r_byte == 8'(pIFG_BYTES - 1)) begin
               w_state_nxt = IDLE;
               w_byte_nxt  = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Abort kills the line on the next beat and discards the rest of the packet in DRAIN.
      if (w_abort) begin
         w_state_nxt = DRAIN;
         w_tx_en_nxt = 1'b0;
         w_load      = 1'b1;
         w_load_byte = 8'h00;
         w_crc_en    = 1'b0;
         w_beat_nxt  = '0;
         w_byte_nxt  = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beat       <= '0;
         r_byte       <= '0;
         r_pay        <= '0;
         r_last_seen  <= 1'b0;
         r_shift      <= 8'h00;
         r_tx_en      <= 1'b0;
         r_crc        <= 32'hFFFFFFFF;
         r_hdr        <= '0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_beat       <= w_beat_nxt;
         r_byte       <= w_byte_nxt;
         r_pay        <= w_pay_nxt;
         r_last_seen  <= w_last_nxt;
         r_tx_en      <= w_tx_en_nxt;
         r_frame_done <= w_done;
         r_underrun   <= w_abort;
         if (w_load) r_shift <= w_load_byte;
         else        r_shift <= r_shift >> pMII_WIDTH;
         if (w_start) begin
            r_crc <= 32'hFFFFFFFF;
            r_hdr <= {i_dest_addr, i_src_addr, i_len_type};
         end else begin
            if (w_crc_en)    r_crc <= crc_byte(r_crc, w_load_byte);
            if (w_hdr_shift) r_hdr <= {r_hdr[103:0], 8'h00};
         end
      end
   end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: RMII and MII instances, full/short/back-to-back,
// underrun and mid-frame reset scenarios checked against hand-built frame bytes.
`timescale 1ns/1ps
module tb_eth_tx_framer;
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_DATA = 4'd6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] dest = '0, src = '0;
   logic [15:0] len_type = '0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, sel4 = 1'b0;
   logic        v2, v4, w_ready;
   logic        ready2, tx_en2, busy2, fd2, ur2;
   logic        ready4, tx_en4, busy4, fd4, ur4;
   logic [1:0]  txd2;
   logic [3:0]  txd4, st2, st4;

   int n_checks = 0, n_fail = 0;
   logic [7:0] exp_q[$];

   assign v2      = s_valid & ~sel4;
   assign v4      = s_valid & sel4;
   assign w_ready = sel4 ? ready4 : ready2;

   eth_tx_framer #(.pMII_WIDTH(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_dest_addr(dest), .i_src_addr(src), .i_len_type(len_type),
      .i_s_data(s_data), .i_s_valid(v2), .i_s_last(s_last), .o_s_ready(ready2), .o_txd(txd2),
      .o_tx_en(tx_en2), .o_busy(busy2), .o_frame_done(fd2), .o_underrun(ur2), .o_state(st2));

   eth_tx_framer #(.pMII_WIDTH(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_dest_addr(dest), .i_src_addr(src), .i_len_type(len_type),
      .i_s_data(s_data), .i_s_valid(v4), .i_s_last(s_last), .o_s_ready(ready4), .o_txd(txd4),
      .o_tx_en(tx_en4), .o_busy(busy4), .o_frame_done(fd4), .o_underrun(ur4), .o_state(st4));

   // clock / reset block
   always #10 clk = ~clk;

   // line monitors: record beats while Tx_En is high, enable lengths, gaps and pulses
   logic [1:0] beat2_q[$];
   logic [3:0] beat4_q[$];
   int on2 = 0, len2 = 0, gap2 = 0, gaprun2 = 0, nfd2 = 0, nur2 = 0, txdbad2 = 0;
   int on4 = 0, len4 = 0, nfd4 = 0, nur4 = 0, txdbad4 = 0;
   logic prev2 = 1'b0, prev4 = 1'b0;

   always @(negedge clk) begin
      if (tx_en2) begin
         beat2_q.push_back(txd2);
         on2++;
         if (!prev2) gap2 = gaprun2;
         gaprun2 = 0;
      end else begin
         if (txd2 !== 2'b00) txdbad2++;
         if (prev2) len2 = on2;
         on2 = 0;
         gaprun2++;
      end
      if (fd2) nfd2++;
      if (ur2) nur2++;
      prev2 = tx_en2;
   end

   always @(negedge clk) begin
      if (tx_en4) begin
         beat4_q.push_back(txd4);
         on4++;
      end else begin
         if (txd4 !== 4'h0) txdbad4++;
         if (prev4) len4 = on4;
         on4 = 0;
      end
      if (fd4) nfd4++;
      if (ur4) nur4++;
      prev4 = tx_en4;
   end

   task automatic clear_mon;
      beat2_q.delete(); beat4_q.delete();
      len2 = 0; gap2 = 0; nfd2 = 0; nur2 = 0; txdbad2 = 0;
      len4 = 0; nfd4 = 0; nur4 = 0; txdbad4 = 0;
      exp_q.delete();
   endtask

   function automatic logic [7:0] rx2_byte(input int k);
      return {beat2_q[4*k+3], beat2_q[4*k+2], beat2_q[4*k+1], beat2_q[4*k]};
   endfunction

   function automatic logic [7:0] rx4_byte(input int k);
      return {beat4_q[2*k+1], beat4_q[2*k]};
   endfunction

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // scoreboard: append the expected on-wire bytes of one frame to exp_q
   task automatic build_exp(input int n, input logic [7:0] base);
      int start;
      logic [31:0] c;
      logic [111:0] hdr;
      start = exp_q.size();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      hdr = {dest, src, len_type};
      for (int i = 0; i < 14; i++) exp_q.push_back(hdr[111 - 8*i -: 8]);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
      for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = start + 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
   endtask

   task automatic set_hdr;
      dest = 48'hFFFF_FFFF_FFFF; src = 48'h0200_0000_0001; len_type = 16'h0800;
   endtask

   // driver: offer n payload bytes; drop_at >= 0 withholds S_Valid before that byte
   task automatic drive_payload(input bit use4, input int n, input logic [7:0] base,
                                input bit keep, input int drop_at, output int sent);
      int idx, budget;
      idx = 0; budget = 0;
      @(posedge clk); #1;
      sel4 = use4; s_data = base; s_last = (n == 1); s_valid = 1'b1;
      while (idx < n && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (w_ready && s_valid) begin
            @(posedge clk); #1;
            idx++;
            if (idx < n) begin
               s_data = base + 8'(idx);
               s_last = (idx == n - 1);
               if (idx == drop_at) begin
                  s_valid = 1'b0;
                  repeat (12) @(posedge clk);
                  #1 s_valid = 1'b1;
               end
            end
         end
      end
      n_checks++;
      if (idx != n) begin
         n_fail++;
         $display("FAIL drive_accept: accepted %0d bytes, want %0d", idx, n);
      end
      if (!keep || idx != n) begin s_valid = 1'b0; s_last = 1'b0; end
      sent = idx;
   endtask

   task automatic wait_idle(input bit use4);
      int b;
      b = 0;
      do begin @(negedge clk); b++; end while ((use4 ? busy4 : busy2) && b < 5000);
      n_checks++;
      if (use4 ? busy4 : busy2) begin
         n_fail++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", b);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; sel4 = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (tx_en2 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", tx_en2); end
      n_checks++; if (txd2 !== 2'b00) begin n_fail++; $display("FAIL reset_txd: got %b want 00", txd2); end
      n_checks++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready2); end
      n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy2); end
      n_checks++; if ({fd2, ur2} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {fd2, ur2}); end
      n_checks++; if (st2 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st2); end
      n_checks++; if ({tx_en4, busy4, txd4} !== 6'd0) begin n_fail++; $display("FAIL reset_mii: got %b want 0", {tx_en4, busy4, txd4}); end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_rmii_frame(input string tag, input int first, input int nbytes);
      logic [31:0] c;
      int bad;
      bad = 0;
      for (int k = first; k < first + nbytes; k++) begin
         n_checks++;
         if (rx2_byte(k) !== exp_q[k]) begin
            n_fail++;
            $display("FAIL %s_byte%0d: got %02h want %02h", tag, k - first, rx2_byte(k), exp_q[k]);
         end
      end
      c = 32'hFFFFFFFF;
      for (int k = first + 8; k < first + nbytes; k++) c = crc_step(c, rx2_byte(k));
      n_checks++;
      if (c !== 32'hDEBB20E3) begin n_fail++; $display("FAIL %s_residue: got %08h want debb20e3", tag, c); end
   endtask

   task automatic test_full_rmii;
      int sent, bad;
      clear_mon(); set_hdr();
      build_exp(64, 8'h00);
      fork
         drive_payload(1'b0, 64, 8'h00, 1'b0, -1, sent);
         begin repeat (30) @(posedge clk); #1 dest = 48'h1234_5678_9ABC; end
      join
      wait_idle(1'b0);
      set_hdr();
      n_checks++; if (len2 != 360) begin n_fail++; $display("FAIL full_len: got %0d want 360", len2); end
      bad = 0;
      for (int k = 0; k < 28; k++) if (beat2_q[k] !== 2'b01) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_preamble: %0d bad beats want 0", bad); end
      n_checks++;
      if ({beat2_q[28], beat2_q[29], beat2_q[30], beat2_q[31]} !== 8'b01_01_01_11) begin
         n_fail++;
         $display("FAIL full_sfd: got %b%b%b%b want 01010111", beat2_q[28], beat2_q[29], beat2_q[30], beat2_q[31]);
      end
      check_rmii_frame("full", 0, 90);
      n_checks++; if (nfd2 != 1) begin n_fail++; $display("FAIL full_done: got %0d pulses want 1", nfd2); end
      n_checks++; if (nur2 != 0) begin n_fail++; $display("FAIL full_underrun: got %0d want 0", nur2); end
      n_checks++; if (txdbad2 != 0) begin n_fail++; $display("FAIL full_txd_idle: %0d nonzero beats want 0", txdbad2); end
   endtask

   task automatic test_short;
      int sent;
      clear_mon(); set_hdr();
      build_exp(10, 8'hA0);
      drive_payload(1'b0, 10, 8'hA0, 1'b0, -1, sent);
      wait_idle(1'b0);
      n_checks++; if (len2 != 288) begin n_fail++; $display("FAIL short_len: got %0d want 288", len2); end
      check_rmii_frame("short", 0, 72);
      n_checks++; if (nfd2 != 1) begin n_fail++; $display("FAIL short_done: got %0d pulses want 1", nfd2); end
   endtask

   task automatic test_back_to_back;
      int s1, s2;
      clear_mon(); set_hdr();
      build_exp(46, 8'h10);
      build_exp(46, 8'h60);
      drive_payload(1'b0, 46, 8'h10, 1'b1, -1, s1);
      drive_payload(1'b0, 46, 8'h60, 1'b0, -1, s2);
      wait_idle(1'b0);
      n_checks++; if (gap2 != 49) begin n_fail++; $display("FAIL b2b_gap: got %0d want 49", gap2); end
      n_checks++; if (len2 != 288) begin n_fail++; $display("FAIL b2b_len: got %0d want 288", len2); end
      n_checks++; if (beat2_q.size() != 576) begin n_fail++; $display("FAIL b2b_beats: got %0d want 576", beat2_q.size()); end
      check_rmii_frame("b2b_first", 0, 72);
      check_rmii_frame("b2b_second", 72, 72);
      n_checks++; if (nfd2 != 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", nfd2); end
   endtask

   task automatic test_underrun;
      int sent;
      clear_mon(); set_hdr();
      build_exp(64, 8'h00);
      drive_payload(1'b0, 64, 8'h00, 1'b0, 20, sent);
      wait_idle(1'b0);
      n_checks++; if (nur2 != 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d want 1", nur2); end
      n_checks++; if (nfd2 != 0) begin n_fail++; $display("FAIL underrun_done: got %0d want 0", nfd2); end
      n_checks++; if (len2 != 168) begin n_fail++; $display("FAIL underrun_len: got %0d want 168", len2); end
      for (int k = 0; k < 42; k++) begin
         n_checks++;
         if (rx2_byte(k) !== exp_q[k]) begin
            n_fail++;
            $display("FAIL underrun_byte%0d: got %02h want %02h", k, rx2_byte(k), exp_q[k]);
         end
      end
      n_checks++; if (txdbad2 != 0) begin n_fail++; $display("FAIL underrun_txd_idle: %0d nonzero beats want 0", txdbad2); end
   endtask

   task automatic test_mii;
      int sent, bad;
      logic [31:0] c;
      clear_mon(); set_hdr();
      build_exp(64, 8'h00);
      drive_payload(1'b1, 64, 8'h00, 1'b0, -1, sent);
      wait_idle(1'b1);
      sel4 = 1'b0;
      n_checks++; if (len4 != 180) begin n_fail++; $display("FAIL mii_len: got %0d want 180", len4); end
      bad = 0;
      for (int k = 0; k < 14; k++) if (beat4_q[k] !== 4'h5) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mii_preamble: %0d bad nibbles want 0", bad); end
      n_checks++;
      if ({beat4_q[14], beat4_q[15]} !== 8'h5D) begin
         n_fail++; $display("FAIL mii_sfd: got %h%h want 5d", beat4_q[14], beat4_q[15]);
      end
      for (int k = 0; k < 90; k++) begin
         n_checks++;
         if (rx4_byte(k) !== exp_q[k]) begin
            n_fail++; $display("FAIL mii_byte%0d: got %02h want %02h", k, rx4_byte(k), exp_q[k]);
         end
      end
      c = 32'hFFFFFFFF;
      for (int k = 8; k < 90; k++) c = crc_step(c, rx4_byte(k));
      n_checks++; if (c !== 32'hDEBB20E3) begin n_fail++; $display("FAIL mii_residue: got %08h want debb20e3", c); end
      n_checks++; if (nfd4 != 1 || nur4 != 0) begin n_fail++; $display("FAIL mii_pulses: done %0d underrun %0d want 1 0", nfd4, nur4); end
      n_checks++; if (txdbad4 != 0) begin n_fail++; $display("FAIL mii_txd_idle: %0d nonzero nibbles want 0", txdbad4); end
   endtask

   task automatic test_reset_mid_frame;
      int b, sent;
      clear_mon(); set_hdr();
      @(posedge clk); #1;
      sel4 = 1'b0; s_data = 8'hAA; s_last = 1'b0; s_valid = 1'b1;
      b = 0;
      do begin @(negedge clk); b++; end while (st2 !== ST_DATA && b < 500);
      n_checks++; if (st2 !== ST_DATA) begin n_fail++; $display("FAIL rstmid_reach_data: state %0d want 6", st2); end
      repeat (8) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if ({tx_en2, txd2} !== 3'b000) begin n_fail++; $display("FAIL rstmid_line: got %b want 000", {tx_en2, txd2}); end
      n_checks++; if ({ready2, busy2, fd2, ur2} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 0000", {ready2, busy2, fd2, ur2}); end
      n_checks++; if (st2 !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", st2); end
      s_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (nfd2 != 0 || nur2 != 0) begin n_fail++; $display("FAIL rstmid_pulses: done %0d underrun %0d want 0 0", nfd2, nur2); end
      clear_mon();
      build_exp(64, 8'h00);
      drive_payload(1'b0, 64, 8'h00, 1'b0, -1, sent);
      wait_idle(1'b0);
      n_checks++; if (len2 != 360) begin n_fail++; $display("FAIL rstmid_len: got %0d want 360", len2); end
      check_rmii_frame("rstmid", 0, 90);
   endtask

   initial begin
      test_reset();
      test_full_rmii();
      test_short();
      test_back_to_back();
      test_underrun();
      test_mii();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
